// File: rtl/s526n_bist_ctrl.sv
// BIST sequencer for the s526n core: LFSR vector source, MISR compactor,
// golden-signature compare.
module s526n_bist_ctrl #(
  parameter int          N_PAT      = 256,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic        blif_clk_net,
  input  logic        blif_reset_net,
  input  logic        start,
  output logic        dut_rst,
  output logic [2:0]  dut_in,
  input  logic [5:0]  dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DUT_RST = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [15:0] LAST = 16'(N_PAT - 1);

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic        load;
  logic [15:0] lfsr;
  logic [15:0] misr;
  logic [15:0] run_cnt;
  logic [1:0]  sub_cnt;
  logic [15:0] lfsr_nx;
  logic [15:0] misr_nx;

  assign lfsr_nx = {lfsr[14:0],
                    lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign misr_nx = {misr[14:0],
                    misr[15] ^ misr[13] ^ misr[12] ^ misr[10]}
                 ^ {10'b0, dut_out};

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = DUT_RST;
          load     = 1'b1;
        end
      end
      DUT_RST: if (sub_cnt == 2'd1) state_nx = RUN;
      RUN:     if (run_cnt == LAST) state_nx = DRAIN;
      DRAIN:   if (sub_cnt == 2'd1) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state   <= IDLE;
      dut_rst <= 1'b1;
      lfsr    <= LFSR_SEED;
      misr    <= 16'h0000;
      run_cnt <= 16'h0000;
      sub_cnt <= 2'd0;
    end else begin
      state   <= state_nx;
      dut_rst <= (state_nx == DUT_RST);
      if (load) begin
        lfsr    <= LFSR_SEED;
        misr    <= 16'h0000;
        run_cnt <= 16'h0000;
        sub_cnt <= 2'd0;
      end else begin
        case (state)
          DUT_RST: begin
            sub_cnt <= (state_nx == state) ? sub_cnt + 2'd1 : 2'd0;
          end
          RUN: begin
            lfsr    <= lfsr_nx;
            misr    <= misr_nx;
            run_cnt <= run_cnt + 16'd1;
          end
          // DRAIN keeps compacting to flush the core's output latency
          DRAIN: begin
            misr    <= misr_nx;
            sub_cnt <= (state_nx == state) ? sub_cnt + 2'd1 : 2'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign dut_in    = (state == RUN) ? lfsr[2:0] : 3'b000;
  assign busy      = (state == DUT_RST) || (state == RUN)
                  || (state == DRAIN);
  assign done      = (state == DONE);
  assign pass      = done && (misr == GOLDEN_SIG);
  assign signature = misr;

endmodule

// File: tb/tb_s526n_bist_ctrl.sv
// Bench for s526n_bist_ctrl: random core responses checked against a
// cycle-indexed reference of the vector stream and signature.
module tb_s526n_bist_ctrl;

  localparam int          NP   = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] GOLD = 16'h0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dut_rst;
  logic [2:0]  dut_in;
  logic [5:0]  dut_out = 6'd0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  int n_chk  = 0;
  int n_fail = 0;

  logic [5:0]  outs [NP+2];
  logic [2:0]  seen_in [NP];
  logic [15:0] sig_a;
  logic [15:0] sig_b;

  always #5 clk = ~clk;

  s526n_bist_ctrl #(
    .N_PAT(NP), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)
  ) dut (
    .blif_clk_net(clk),
    .blif_reset_net(rst),
    .start(start),
    .dut_rst(dut_rst),
    .dut_in(dut_in),
    .dut_out(dut_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .signature(signature)
  );

  function automatic logic [15:0] shift16(input logic [15:0] v,
                                          input logic [5:0] inj);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]} ^ {10'b0, inj};
  endfunction

  // mode: 0 zeros, 1 first RUN cycle only, 2 new random, 3 replay
  task automatic run(input int mode, input bit pulses, input bit keep,
                     output logic [15:0] sig_got);
    logic [15:0] l;
    logic [15:0] s;
    logic [2:0]  ein;
    bit          in_run;
    for (int i = 0; i < NP + 2; i++) begin
      if (mode == 0) outs[i] = 6'd0;
      else if (mode == 1) outs[i] = (i == 0) ? 6'h01 : 6'h00;
      else if (mode == 2) outs[i] = 6'($urandom);
    end
    l = SEED;
    s = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= NP + 4; c++) begin
      @(negedge clk);
      in_run = (c >= 3) && (c <= NP + 2);
      ein = in_run ? l[2:0] : 3'b000;
      if (in_run) seen_in[c-3] = dut_in;
      n_chk++;
      if (dut_rst !== (c <= 2) || busy !== 1'b1 || done !== 1'b0
          || pass !== 1'b0 || dut_in !== ein) begin
        n_fail++;
        $display("FAIL busy_cycle%0d: rst=%b busy=%b done=%b pass=%b in=%b want rst=%b busy=1 done=0 pass=0 in=%b",
                 c, dut_rst, busy, done, pass, dut_in, c <= 2, ein);
      end
      if (in_run) l = shift16(l, 6'd0);
      start = keep | (pulses && c >= 3);
      dut_out = (c >= 3) ? outs[c-3] : 6'($urandom);
      if (c >= 3) s = shift16(s, dut_out);
    end
    @(negedge clk);
    sig_got = signature;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || dut_rst !== 1'b0
        || dut_in !== 3'b000 || signature !== s || pass !== (s == GOLD)) begin
      n_fail++;
      $display("FAIL done_state: done=%b busy=%b rst=%b in=%b sig=%h pass=%b want 1 0 0 000 sig=%h pass=%b",
               done, busy, dut_rst, dut_in, signature, pass, s, s == GOLD);
    end
    if (!keep) begin
      start = 1'b0;
      dut_out = 6'($urandom);
      @(negedge clk);
      n_chk++;
      if (done !== 1'b1 || signature !== s || pass !== (s == GOLD)) begin
        n_fail++;
        $display("FAIL done_hold: done=%b sig=%h pass=%b want 1 %h %b",
                 done, signature, pass, s, s == GOLD);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (dut_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0
        || signature !== 16'h0 || dut_in !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_vals: rst=%b busy=%b done=%b pass=%b sig=%h in=%b want 1 0 0 0 0000 000",
               dut_rst, busy, done, pass, signature, dut_in);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (dut_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_registered: dut_rst=%b want 1", dut_rst);
    end
    @(negedge clk);
    n_chk++;
    if (dut_rst !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: rst=%b busy=%b done=%b want 0 0 0",
               dut_rst, busy, done);
    end
  endtask

  task automatic test_zero_run;
    logic [15:0] sg;
    run(0, 1'b0, 1'b0, sg);
    n_chk++;
    if (seen_in[0] !== 3'b001 || seen_in[1] !== 3'b011) begin
      n_fail++;
      $display("FAIL first_vectors: got %b %b want 001 011",
               seen_in[0], seen_in[1]);
    end
    n_chk++;
    if (sg !== 16'h0000) begin
      n_fail++;
      $display("FAIL zero_sig: got %h want 0000", sg);
    end
  endtask

  task automatic test_first_only;
    logic [15:0] sg;
    run(1, 1'b0, 1'b0, sg);
    n_chk++;
    if (sg !== 16'h0020 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hit: sig=%h pass=%b want 0020 1", sg, pass);
    end
  endtask

  task automatic test_random;
    logic [15:0] sg;
    for (int k = 0; k < 6; k++) run(2, 1'b0, 1'b0, sg);
    sig_a = sg;
  endtask

  task automatic test_start_pulses;
    logic [15:0] sg;
    run(3, 1'b1, 1'b0, sg);
    n_chk++;
    if (sg !== sig_a) begin
      n_fail++;
      $display("FAIL pulses_sig: got %h want %h", sg, sig_a);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] sg;
    run(2, 1'b0, 1'b0, sig_b);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dut_out = 6'($urandom);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (dut_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0
        || signature !== 16'h0 || dut_in !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: rst=%b busy=%b done=%b pass=%b sig=%h in=%b want 1 0 0 0 0000 000",
               dut_rst, busy, done, pass, signature, dut_in);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(3, 1'b0, 1'b0, sg);
    n_chk++;
    if (sg !== sig_b) begin
      n_fail++;
      $display("FAIL rerun_after_reset: got %h want %h", sg, sig_b);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s1;
    logic [15:0] s2;
    run(2, 1'b0, 1'b1, s1);
    run(3, 1'b0, 1'b0, s2);
    n_chk++;
    if (s1 !== s2) begin
      n_fail++;
      $display("FAIL back_to_back: second %h first %h", s2, s1);
    end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_first_only();
    test_random();
    test_start_pulses();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/s526n_bist_ctrl.md
# s526n_bist_ctrl

Built-in self-test sequencer for the s526n benchmark core. It drives the core's reset and its three primary inputs (G0, G1, G2) with a pseudo-random vector stream from a 16-bit LFSR, compacts the six primary outputs into a 16-bit MISR, and compares the final signature against a golden value. It sits beside the s526n instance in the clock-mesh evaluation harness and shares the same clock net, so one BIST run exercises every flop on the mesh.

## Interface

Parameters:
- N_PAT, 256: number of RUN cycles (vectors applied); legal range 1..65535.
- LFSR_SEED, 16'hACE1: LFSR load value at every run start; must be nonzero.
- GOLDEN_SIG, 16'h0000: expected final MISR value.

Ports:
- blif_clk_net  in  1  clock, rising edge.
- blif_reset_net  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- dut_rst  out  1  reset to the s526n instance.
- dut_in  out  3  {G2,G1,G0} to the s526n instance.
- dut_out  in  6  {G214,G213,G199,G198,G148,G147} from the s526n instance.
- busy  out  1  high in DUT_RST, RUN, DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1: signature==GOLDEN_SIG.
- signature  out  16  current MISR contents.

## Operation

- States: IDLE, DUT_RST, RUN, DRAIN, DONE.
- IDLE: start=1 -> DUT_RST; load LFSR with LFSR_SEED, clear MISR to 0, clear the cycle counter.
- DUT_RST: 2 cycles with dut_rst=1, dut_in=0; then -> RUN.
- RUN: N_PAT cycles. dut_in = lfsr[2:0]. Each cycle the LFSR advances and the MISR captures dut_out. After the N_PAT-th cycle -> DRAIN.
- DRAIN: 2 cycles. dut_in=0; MISR keeps capturing (flushes the DUT's registered-output latency). Then -> DONE.
- DONE: done=1, busy=0, signature and pass held. start=1 -> DUT_RST with the same loads as IDLE. Otherwise remain in DONE.
- start while busy is ignored.
- LFSR: fb = l[15]^l[13]^l[12]^l[10]; l_next = {l[14:0], fb}.
- MISR: fb = s[15]^s[13]^s[12]^s[10]; s_next = {s[14:0], fb} ^ {10'b0, dut_out}.
- Counter: 16 bits, counts RUN cycles, and separately DUT_RST/DRAIN cycles (2-bit sub-counter); no wrap for legal N_PAT.
- pass = done & (signature == GOLDEN_SIG); 0 outside DONE.

## Timing

- Reset values: state=IDLE, dut_rst=1, dut_in=0, busy=0, done=0, pass=0, signature=0, LFSR=LFSR_SEED.
- dut_rst is registered. It falls on the first clock edge after reset release in IDLE and is 1 exactly while in DUT_RST.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- start=1 at edge t: DUT_RST covers cycles t+1..t+2. RUN covers t+3..t+N_PAT+2. DRAIN covers the next 2 cycles. done rises at cycle t+N_PAT+5.
- MISR capture edges: end of every RUN and DRAIN cycle, N_PAT+2 captures per run.
- Reset asserted mid-run: immediate return to reset values. No partial signature is reported, and dut_rst goes high asynchronously.
- start held high continuously: the block reruns back-to-back. DONE lasts one cycle per run.

## Test plan

- Reset, start pulse, N_PAT=4, dut_out tied 0 -> dut_in sequence during RUN = 3'b001, 3'b011, then the next two LFSR values. done at start+9, signature=0x0000, pass=1 (GOLDEN_SIG=0).
- N_PAT=4, dut_out=6'h01 only during the first RUN cycle, 0 otherwise -> signature=0x0020 at done. pass=0 with GOLDEN_SIG=0, pass=1 with GOLDEN_SIG=16'h0020.
- dut_rst check: dut_rst=1 during reset and exactly 2 cycles after start, 0 elsewhere; busy=1 for N_PAT+4 cycles.
- start pulses during RUN and DRAIN -> no effect. Timing and signature are identical to the run without the extra pulses.
- Reset asserted mid-RUN -> all outputs return to reset values asynchronously. A new start yields the same signature as a clean run.
- Integration with the real s526n and N_PAT=256: two consecutive runs give identical signatures. That value becomes GOLDEN_SIG, and a stuck-at fault injected on G147 gives pass=0.
